// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core front end: immediate-extend opcodes,
// the bubble instruction word and the default reset PC.
package mips_pkg;

  localparam logic [5:0]  OP_ANDI          = 6'h0C;
  localparam logic [5:0]  OP_ORI           = 6'h0D;
  localparam logic [5:0]  OP_XORI          = 6'h0E;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Logical-immediate ops zero-extend their immediate; everything else sign-extends.
  function automatic logic is_zero_ext_op(input logic [5:0] opcode);
    return (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC selection: taken branch, then stall hold,
// then jump, then sequential PC+4.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] pc4
);

  logic [31:0] pc_cur_reg;
  logic [31:0] pc_next;

  assign pc  = pc_cur_reg;
  assign pc4 = pc_cur_reg + 32'd4;

  // A resolved branch must redirect even under a stall, otherwise the wrong
  // path would keep fetching; a jump simply waits out the stall.
  always_comb begin
    pc_next = pc4;
    if (branch_taken) begin
      pc_next = branch_target;
    end else if (stall) begin
      pc_next = pc_cur_reg;
    end else if (jump) begin
      pc_next = jump_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_cur_reg <= RESET_PC;
    end else begin
      pc_cur_reg <= pc_next;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register, including the registered
// zero/sign-extend decision handed to the ID-stage sign extender.
module if_id_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [15:0] id_immed,
  output logic        id_extnd_decide,
  output logic [31:0] fetch_count
);

  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] instr_reg;
  logic [31:0] pc4_reg;
  logic        valid_reg;
  logic        extnd_reg;
  logic [31:0] count_reg;
  logic        load_bubble;
  logic        load_normal;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .pc           (pc),
    .pc4          (pc4)
  );

  // Any redirect squashes the instruction fetched down the old path; flush wins over stall.
  assign load_bubble = flush | branch_taken | (jump & ~stall);
  assign load_normal = ~load_bubble & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg <= NOP_INSTR;
      pc4_reg   <= 32'd0;
      valid_reg <= 1'b0;
      extnd_reg <= 1'b0;
      count_reg <= 32'd0;
    end else if (load_bubble) begin
      instr_reg <= NOP_INSTR;
      pc4_reg   <= 32'd0;
      valid_reg <= 1'b0;
      extnd_reg <= 1'b0;
    end else if (load_normal) begin
      instr_reg <= imem_rdata;
      pc4_reg   <= pc4;
      valid_reg <= 1'b1;
      extnd_reg <= is_zero_ext_op(imem_rdata[31:26]);
      count_reg <= count_reg + 32'd1;
    end
  end

  assign imem_addr       = pc;
  assign if_id_instr     = instr_reg;
  assign if_id_pc4       = pc4_reg;
  assign if_id_valid     = valid_reg;
  assign id_immed        = instr_reg[15:0];
  assign id_extnd_decide = extnd_reg;
  assign fetch_count     = count_reg;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: a fetch-level reference model checked every
// cycle, plus hand-computed literal expectations from the test plan.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [15:0] id_immed;
  logic        id_extnd_decide;
  logic [31:0] fetch_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model state: what the pipeline must hold after each edge.
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_ext;

  if_id_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .flush          (flush),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .if_id_instr    (if_id_instr),
    .if_id_pc4      (if_id_pc4),
    .if_id_valid    (if_id_valid),
    .id_immed       (id_immed),
    .id_extnd_decide(id_extnd_decide),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0005;  // addi
      32'h0000_0004: return 32'h3109_00FF;  // andi
      32'h0000_0008: return 32'h3509_1234;  // ori
      32'h0000_000C: return 32'h3909_ABCD;  // xori
      32'h0000_0010: return 32'h1109_0003;  // beq
      default:       return 32'h8C00_0000 | {16'h0, a[15:0]};  // lw
    endcase
  endfunction

  assign imem_rdata = imem(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
    m_valid = 1'b0; m_ext = 1'b0; m_count = 32'h0;
  endtask

  // One clock edge of fetch behaviour, described as "what happens to the
  // instruction at the current PC" rather than as registers and muxes.
  task automatic model_step();
    logic [31:0] fetched;
    logic [5:0]  op;
    logic        redirect;
    if (!rst_n) begin
      model_reset();
      return;
    end
    fetched  = imem(m_pc);
    op       = fetched[31:26];
    redirect = flush || branch_taken || (jump && !stall);
    if (redirect) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_ext = 1'b0;
    end else if (!stall) begin
      m_instr = fetched;
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_ext   = (op inside {6'h0C, 6'h0D, 6'h0E});
      m_count = m_count + 32'd1;
    end
    if (branch_taken)  m_pc = branch_target;
    else if (stall)    m_pc = m_pc;
    else if (jump)     m_pc = jump_target;
    else               m_pc = m_pc + 32'd4;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    $display("[TB] t=%0t pc=%h instr=%h pc4=%h valid=%0b ext=%0b cnt=%0d",
             $time, imem_addr, if_id_instr, if_id_pc4, if_id_valid,
             id_extnd_decide, fetch_count);
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_addr",   imem_addr,               m_pc);
      check("if_id_instr", if_id_instr,             m_instr);
      check("if_id_pc4",   if_id_pc4,               m_pc4);
      check("if_id_valid", {31'd0, if_id_valid},    {31'd0, m_valid});
      check("id_immed",    {16'd0, id_immed},       {16'd0, m_instr[15:0]});
      check("id_extnd",    {31'd0, id_extnd_decide},{31'd0, m_ext});
      check("fetch_count", fetch_count,             m_count);
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_en = 1'b1;
    tick();
    tick();
    check("rst_pc",    imem_addr,   32'h0);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    rst_n = 1'b1;

    // Sequential run
    tick();
    check("e1_pc",    imem_addr,   32'h4);
    check("e1_instr", if_id_instr, 32'h2008_0005);
    check("e1_immed", {16'd0, id_immed}, 32'h0005);
    check("e1_ext",   {31'd0, id_extnd_decide}, 32'd0);
    check("e1_pc4",   if_id_pc4,   32'h4);
    check("e1_valid", {31'd0, if_id_valid}, 32'd1);
    tick();
    check("e2_immed", {16'd0, id_immed}, 32'h00FF);
    check("e2_ext",   {31'd0, id_extnd_decide}, 32'd1);
    check("e2_count", fetch_count, 32'd2);

    // Stall two cycles at PC=8
    stall = 1'b1;
    tick();
    tick();
    check("stall_pc",    imem_addr,   32'h8);
    check("stall_instr", if_id_instr, 32'h3109_00FF);
    check("stall_count", fetch_count, 32'd2);
    stall = 1'b0;
    tick();
    check("rel_pc",    imem_addr,   32'hC);
    check("rel_instr", if_id_instr, 32'h3509_1234);
    tick();

    // Branch beats stall at PC=16
    check("pre_br_pc", imem_addr, 32'h10);
    branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1;
    tick();
    check("br_pc",    imem_addr,   32'h40);
    check("br_valid", {31'd0, if_id_valid}, 32'd0);
    check("br_instr", if_id_instr, 32'h0);
    check("br_count", fetch_count, 32'd4);
    branch_taken = 1'b0;

    // Jump held off by stall, taken once stall drops
    jump = 1'b1; jump_target = 32'h100;
    tick();
    check("jst_pc", imem_addr, 32'h40);
    stall = 1'b0;
    tick();
    check("j_pc",    imem_addr, 32'h100);
    check("j_valid", {31'd0, if_id_valid}, 32'd0);
    jump = 1'b0;
    tick();
    check("j_instr", if_id_instr, 32'h8C00_0100);
    check("j_count", fetch_count, 32'd5);

    // Flush beats stall; PC holds
    flush = 1'b1; stall = 1'b1;
    tick();
    check("fl_pc",    imem_addr, 32'h104);
    check("fl_valid", {31'd0, if_id_valid}, 32'd0);
    flush = 1'b0; stall = 1'b0;
    tick();

    // Async reset between edges at PC=0x80
    branch_taken = 1'b1; branch_target = 32'h80;
    tick();
    branch_taken = 1'b0;
    check("pre_rst_pc", imem_addr, 32'h80);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_pc",    imem_addr, 32'h0);
    check("arst_valid", {31'd0, if_id_valid}, 32'd0);
    check("arst_count", fetch_count, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_instr", if_id_instr, 32'h2008_0005);

    // PC wrap at the top of the address space
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    check("top_pc", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc",    imem_addr, 32'h0);
    check("wrap_pc4",   if_id_pc4, 32'h0);
    check("wrap_valid", {31'd0, if_id_valid}, 32'd1);
    check("wrap_count", fetch_count, 32'd2);

    // Mixed control patterns, checked by the per-cycle model compare
    for (int i = 0; i < 40; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      jump          = ($urandom_range(0, 5) == 0);
      branch_target = {$urandom_range(0, 63), 2'b00};
      jump_target   = {$urandom_range(0, 63), 2'b00};
      tick();
    end
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    tick();

    @(posedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch stage plus IF/ID pipeline register of the pipelined MIPS core.
- Holds the PC, drives the instruction-memory address and selects next PC (sequential / taken branch / jump).
- Latches the fetched instruction and PC+4 into IF/ID.
- Registers the zero-extend decision (andi/ori/xori) so the ID-stage sign_extend gets immed_in and extndDecide directly from this block.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000: instruction word placed in IF/ID for a bubble.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  current PC, to instruction memory. Memory read is combinational.
- imem_rdata  in  32  instruction at imem_addr, same cycle.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  squash IF/ID contents at next edge.
- branch_taken  in  1  branch resolved taken in EX.
- branch_target  in  32  target for branch_taken.
- jump  in  1  j/jal decoded in ID.
- jump_target  in  32  target for jump.
- if_id_instr  out  32  IF/ID instruction.
- if_id_pc4  out  32  IF/ID PC+4.
- if_id_valid  out  1  IF/ID holds a real instruction.
- id_immed  out  16  if_id_instr[15:0], to sign_extend immed_in.
- id_extnd_decide  out  1  1 = zero-extend, to sign_extend extndDecide.
- fetch_count  out  32  valid instructions loaded into IF/ID since reset.

Behaviour:
- Reset: rst_n low asynchronously forces the following values and holds them while low.
  - PC = RESET_PC.
  - if_id_instr = NOP_INSTR, if_id_pc4 = 0.
  - if_id_valid = 0, id_extnd_decide = 0, fetch_count = 0.
  - First fetch uses RESET_PC on the first edge after rst_n rises.
- Combinational outputs:
  - imem_addr = PC.
  - pc4 = PC + 32'd4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - id_immed = if_id_instr[15:0].
- Per rising edge, PC update, highest priority first:
  1. branch_taken: PC <= branch_target. Overrides stall and jump.
  2. stall: PC holds. A jump is ignored while stall is high and is taken once stall drops.
  3. jump: PC <= jump_target.
  4. otherwise: PC <= pc4.
- Per rising edge, IF/ID update, highest priority first:
  1. flush, branch_taken, or (jump & ~stall): load a bubble.
     - Bubble = instr NOP_INSTR, pc4 0, valid 0, extnd_decide 0.
     - Flush beats stall.
  2. stall: all IF/ID fields hold.
  3. otherwise: normal load.
     - instr <= imem_rdata, pc4 <= pc4, valid <= 1.
     - extnd_decide <= 1 when imem_rdata[31:26] is 6'h0C, 6'h0D or 6'h0E; else 0.
- Extend rule: all other opcodes, including addi/lw/sw/beq, sign-extend (extnd_decide 0).
- Latency: instruction at PC appears on if_id_instr one edge after the fetch. id_immed/id_extnd_decide become valid in the same cycle as if_id_instr.
- fetch_count increments by 1 on each normal load; it never changes on bubble or hold. Wraps 32'hFFFF_FFFF to 0.
- No internal FSM beyond the run/hold/redirect priority above. All state is in PC, IF/ID and fetch_count.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_ANDI=6'h0C, OP_ORI=6'h0D, OP_XORI=6'h0E.
  - NOP word.
  - default reset PC.
- One sub-module, pc_reg: async active-low reset PC register with the next-PC priority mux.
- IF/ID register, extend decode and counter stay in if_id_stage.

Test Plan:
- Reset/sequential run: rst_n low then high, imem returns 32'h2008_0005 (addi) at 0 and 32'h3109_00FF (andi) at 4.
  - Edge 1: imem_addr=0→4; if_id_instr=32'h2008_0005, id_immed=16'h0005, id_extnd_decide=0, pc4=4, valid=1.
  - Edge 2: id_immed=16'h00FF, id_extnd_decide=1, fetch_count=2.
- Stall: stall high for 2 cycles at PC=8.
  - imem_addr stays 8; IF/ID unchanged; fetch_count unchanged.
  - After release, PC=12 on the next edge.
- Branch beats stall: branch_taken=1, branch_target=32'h40, stall=1, PC=16 → PC=32'h40, if_id_valid=0, if_id_instr=0, fetch_count unchanged.
- Jump gated by stall: jump=1, jump_target=32'h100 with stall=1 for 1 cycle, then stall=0.
  - First edge: PC holds.
  - Second edge: PC=32'h100 and IF/ID bubble.
- Flush vs stall: flush=1, stall=1 → IF/ID bubble (valid=0), PC holds.
- Async reset mid-run and wrap:
  - Drop rst_n between edges at PC=32'h80 → PC=0, valid=0 immediately, with no clock edge.
  - Separately, PC=32'hFFFF_FFFC advances to 0 with if_id_pc4=0.
